alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer around one alu_1bit slice: accepts a WIDTH-bit operand pair plus 3-bit op,

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_1bit.sv | 39 +++
 rtl/alu_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_serial_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode-class helpers
// for the bit-serial ALU sequencer.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_ADD2 = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Ops that subtract: B is inverted and the carry chain starts at 1.
    function automatic logic is_sub_like(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops whose carry-out and overflow flags are reported.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADD2) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice in the classic MIPS style: AND/OR/ADD/NAND/NOR with
// optional B inversion, carry in/out, and a Less input for SLT.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [2:0] operation,
    output logic       result,
    output logic       carry_out
);

    logic b_eff;
    logic sum;

    assign b_eff     = b ^ binvert;
    assign sum       = a ^ b_eff ^ carry_in;
    assign carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = a & b_eff;
            OP_OR:   result = a | b_eff;
            OP_ADD:  result = sum;
            OP_NAND: result = ~(a & b_eff);
            OP_NOR:  result = ~(a | b_eff);
            OP_ADD2: result = sum;
            OP_SUB:  result = sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: streams a WIDTH-bit operand pair LSB-first through
// one alu_1bit slice and returns result and flags on a valid/ready channel.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] idx;

    logic             slice_res;
    logic             slice_cout;
    logic [2:0]       slice_op;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] next_result;

    // SLT runs the slice as a subtract; its answer is the final sign bit.
    assign slice_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
    assign shift_val = {slice_res, res_sr};

    always_comb begin
        next_result = shift_val;
        if (op_q == OP_SLT) begin
            next_result = {{(WIDTH-1){1'b0}}, slice_res};
        end
    end

    alu_1bit u_slice (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .binvert   (is_sub_like(op_q)),
        .carry_in  (carry_q),
        .less      (1'b0),
        .operation (slice_op),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            op_q       <= OP_AND;
            carry_q    <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        a_sr     <= in_a;
                        b_sr     <= in_b;
                        op_q     <= in_op;
                        carry_q  <= is_sub_like(in_op);
                        idx      <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        a_sr    <= a_sr >> 1;
                        b_sr    <= b_sr >> 1;
                        res_sr  <= shift_val[WIDTH-1:1];
                        carry_q <= slice_cout;
                        if (idx == LAST_IDX) begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b1;
                            out_result <= next_result;
                            out_zero   <= (next_result == '0);
                            // Flags from the MSB step: carry_q is the carry into the MSB.
                            out_cout   <= is_arith(op_q) & slice_cout;
                            out_ovf    <= is_arith(op_q) & (carry_q ^ slice_cout);
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Abort and a consumer handshake both release the result; abort just
                    // means the response counts as never issued.
                    if (abort || out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=8) with
// hand-computed expected results, flags and handshake timing.
module tb_alu_serial_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_cout;
    logic       out_ovf;
    logic       out_zero;

    int checks;
    int failures;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request in IDLE; returns #1 after the accepting edge.
    task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic abort_in_idle);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        abort    = abort_in_idle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    // Count edges from the accept edge to out_valid, then check the response.
    task automatic collect(input string tag, input logic [7:0] er, input logic ec,
                           input logic eo, input logic ez, input logic release_it);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 30);
        check({tag, " latency"}, n, 8);
        check({tag, " result"}, out_result, er);
        check({tag, " cout"}, out_cout, ec);
        check({tag, " ovf"}, out_ovf, eo);
        check({tag, " zero"}, out_zero, ez);
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] er, input logic ec,
                         input logic eo, input logic ez);
        send(tag, a, b, op, 1'b0);
        collect(tag, er, ec, eo, ez, 1'b1);
    endtask

    initial begin
        int seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_result", out_result, 8'h00);
        check("rst out_zero", out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic incl. signed overflow and carry-out boundaries.
        do_op("add_ovf", 8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("sub_neg", 8'h05, 8'h07, 3'b110, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_eq",  8'h07, 8'h07, 3'b110, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op("add101",  8'hFF, 8'h01, 3'b101, 8'h00, 1'b1, 1'b0, 1'b1);

        // SLT is the raw sign of A-B; 0x80-0x01 = 0x7F wraps, so its sign bit is 0.
        do_op("slt_lt",  8'h03, 8'h05, 3'b111, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("slt_gt",  8'h05, 8'h03, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("slt_wrap", 8'h80, 8'h01, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1);

        do_op("nor",  8'hF0, 8'h0F, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("nand", 8'hF0, 8'hFF, 3'b011, 8'h0F, 1'b0, 1'b0, 1'b0);
        do_op("and",  8'hCC, 8'hAA, 3'b000, 8'h88, 1'b0, 1'b0, 1'b0);
        do_op("or",   8'hCC, 8'hAA, 3'b001, 8'hEE, 1'b0, 1'b0, 1'b0);

        // Abort presented together with the request in IDLE is ignored.
        send("abort_idle", 8'h12, 8'h34, 3'b010, 1'b1);
        collect("abort_idle", 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

        // Consumer stall in DONE with a competing request.
        send("stall", 8'h12, 8'h34, 3'b010, 1'b0);
        collect("stall", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 8'hFF;
            in_b     = 8'hFF;
            in_op    = 3'b001;
            @(negedge clk);
            check("stall out_valid", out_valid, 1);
            check("stall out_result", out_result, 8'h46);
            check("stall in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall release in_ready", in_ready, 1);
        check("stall release out_valid", out_valid, 0);
        do_op("after_stall", 8'h0F, 8'h01, 3'b010, 8'h10, 1'b0, 1'b0, 1'b0);

        // Abort in RUN at idx=3: no response ever appears.
        send("abort_run", 8'h55, 8'h22, 3'b010, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_run in_ready", in_ready, 1);
        check("abort_run out_valid", out_valid, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_run no response", seen, 0);

        // Abort wins over out_ready in DONE.
        send("abort_done", 8'h01, 8'h01, 3'b010, 1'b0);
        collect("abort_done", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("abort_done out_valid", out_valid, 0);
        check("abort_done in_ready", in_ready, 1);

        // Leave a non-zero result with cout set, then reset asynchronously mid-RUN.
        do_op("pre_rst", 8'hFF, 8'h02, 3'b010, 8'h01, 1'b1, 1'b0, 1'b0);
        send("rst_run", 8'hA5, 8'h5A, 3'b001, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_run in_ready", in_ready, 1);
        check("rst_run out_valid", out_valid, 0);
        check("rst_run out_result", out_result, 8'h00);
        check("rst_run out_cout", out_cout, 0);
        check("rst_run out_zero", out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 8'hA5, 8'h5A, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
